// File: rtl/ro_puf_pkg.sv
// Shared types and index math for the ring-oscillator PUF evaluator.
// Challenge fields are 8 bits wide; only the low log2(NUM_RO) bits matter.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_COUNT,
      ST_COMPARE,
      ST_DONE
   } state_e;

   localparam int CH_BASE_LSB = 0;
   localparam int CH_OFS_LSB  = 8;
   localparam int CH_FIELD_W  = 8;

   // Caller truncates the sum to the RO index width (mod NUM_RO).
   function automatic logic [CH_FIELD_W-1:0] ro_idx(
      input logic [CH_FIELD_W-1:0] base,
      input logic [CH_FIELD_W-1:0] k,
      input logic [CH_FIELD_W-1:0] ofs
   );
      return base + k + ofs;
   endfunction

endpackage

// File: rtl/ro_puf_eval_core_counter.sv
// One measurement channel: 2-FF synchronizer, rising-edge detect and
// a clearable counter that saturates instead of wrapping.
module ro_edge_counter
   import ro_puf_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ro_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [2:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise;

   assign rise  = sync_q[1] & ~sync_q[2];
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && rise && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[1:0], ro_i};
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/ro_puf_eval_core.sv
// RO PUF evaluator: per response bit, enable an RO pair, settle, count
// edges on both for a fixed window and record which one ran faster.
module ro_puf_eval_core
   import ro_puf_pkg::*;
#(
   parameter int NUM_RO    = 16,
   parameter int CNT_W     = 16,
   parameter int WINDOW    = 1024,
   parameter int SETTLE    = 16,
   parameter int RESP_BITS = 32
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 start,
   input  logic [31:0]          challenge,
   input  logic [NUM_RO-1:0]    ro_in,
   output logic [NUM_RO-1:0]    ro_en,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic                 err,
   output logic [5:0]           tie_cnt
);

   localparam int IW = $clog2(NUM_RO);
   localparam int TW = $clog2(WINDOW + SETTLE) + 1;
   localparam int KW = 6;

   state_e               state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [KW-1:0]        k_q, k_d;
   logic [IW-1:0]        base_q, base_d;
   logic [IW-1:0]        ofs_q, ofs_d;
   logic [RESP_BITS-1:0] shf_q, shf_d;
   logic [RESP_BITS-1:0] resp_q, resp_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic [5:0]           tie_q, tie_d;

   logic [IW-1:0]        ia, ib;
   logic [CNT_W-1:0]     cnt_a, cnt_b;
   logic                 run;
   logic                 unused_chal;

   assign unused_chal = ^challenge;

   assign ia = IW'(ro_idx(8'(base_q), 8'(k_q), 8'd0));
   assign ib = IW'(ro_idx(8'(base_q), 8'(k_q), 8'(ofs_q)));

   assign run = (state_q == ST_SETTLE) ||
                (state_q == ST_COUNT) ||
                (state_q == ST_COMPARE);

   assign ro_en    = run ? ((NUM_RO'(1) << ia) | (NUM_RO'(1) << ib))
                         : '0;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign response = resp_q;
   assign err      = err_q;
   assign tie_cnt  = tie_q;

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk_i  (ACLK),
      .rst_ni (ARESETN),
      .ro_i   (ro_in[ia]),
      .clr_i  (state_q == ST_SETTLE),
      .en_i   (state_q == ST_COUNT),
      .cnt_o  (cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk_i  (ACLK),
      .rst_ni (ARESETN),
      .ro_i   (ro_in[ib]),
      .clr_i  (state_q == ST_SETTLE),
      .en_i   (state_q == ST_COUNT),
      .cnt_o  (cnt_b)
   );

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      k_d     = k_q;
      base_d  = base_q;
      ofs_d   = ofs_q;
      shf_d   = shf_q;
      resp_d  = resp_q;
      err_d   = err_q;
      tie_d   = tie_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d = challenge[CH_BASE_LSB +: IW];
               ofs_d  = challenge[CH_OFS_LSB +: IW];
               err_d  = 1'b0;
               tie_d  = '0;
               shf_d  = '0;
               k_d    = '0;
               tmr_d  = '0;
               // A zero offset would compare an RO with itself.
               if (challenge[CH_OFS_LSB +: IW] == '0) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (tmr_q == TW'(SETTLE - 1)) begin
               tmr_d   = '0;
               state_d = ST_COUNT;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_COUNT: begin
            if (tmr_q == TW'(WINDOW - 1)) begin
               tmr_d   = '0;
               state_d = ST_COMPARE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_COMPARE: begin
            if (cnt_a > cnt_b) begin
               shf_d = shf_q | (RESP_BITS'(1) << k_q);
            end
            if (cnt_a == cnt_b) begin
               tie_d = tie_q + 1'b1;
            end
            if (k_q == KW'(RESP_BITS - 1)) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            resp_d  = shf_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         k_q     <= '0;
         base_q  <= '0;
         ofs_q   <= '0;
         shf_q   <= '0;
         resp_q  <= '0;
         err_q   <= 1'b0;
         tie_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         k_q     <= k_d;
         base_q  <= base_d;
         ofs_q   <= ofs_d;
         shf_q   <= shf_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
         tie_q   <= tie_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_ro_puf_eval_core.sv
// Scoreboard bench for ro_puf_eval_core with synthetic RO waveforms.
// Expected results are queued at start and retired on done.
module tb_ro_puf_eval_core;

   localparam int NUM_RO    = 16;
   localparam int CNT_W     = 16;
   localparam int WINDOW    = 1024;
   localparam int SETTLE    = 16;
   localparam int RESP_BITS = 4;
   localparam int LAT = RESP_BITS * (SETTLE + WINDOW + 1) + 2;

   typedef struct {
      logic [RESP_BITS-1:0] resp;
      logic [5:0]           tie;
      logic                 err;
      int                   lat;
   } exp_t;

   logic                 ACLK;
   logic                 ARESETN;
   logic                 start;
   logic [31:0]          challenge;
   logic [NUM_RO-1:0]    ro_in;
   logic [NUM_RO-1:0]    ro_en;
   logic                 busy;
   logic                 done;
   logic [RESP_BITS-1:0] response;
   logic                 err;
   logic [5:0]           tie_cnt;

   int                   vectors;
   int                   miscompares;
   int                   mode;
   logic [RESP_BITS-1:0] last_resp;
   exp_t                 sb[$];

   ro_puf_eval_core #(
      .NUM_RO    (NUM_RO),
      .CNT_W     (CNT_W),
      .WINDOW    (WINDOW),
      .SETTLE    (SETTLE),
      .RESP_BITS (RESP_BITS)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .start     (start),
      .challenge (challenge),
      .ro_in     (ro_in),
      .ro_en     (ro_en),
      .busy      (busy),
      .done      (done),
      .response  (response),
      .err       (err),
      .tie_cnt   (tie_cnt)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // mode 0: RO i half-period 3+i; 1: 18-i; 2: all equal at 4
   initial begin
      int rc [NUM_RO];
      int pm;
      int p;
      ro_in = '0;
      pm = -1;
      forever begin
         @(negedge ACLK);
         if (mode != pm) begin
            pm = mode;
            ro_in = '0;
            for (int i = 0; i < NUM_RO; i++) rc[i] = 0;
         end else begin
            for (int i = 0; i < NUM_RO; i++) begin
               p = (mode == 0) ? 3 + i : (mode == 1) ? 18 - i : 4;
               if (rc[i] >= p - 1) begin
                  rc[i] = 0;
                  ro_in[i] = ~ro_in[i];
               end else begin
                  rc[i]++;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_eval(input logic [31:0]          chal,
                           input logic [RESP_BITS-1:0] er,
                           input logic [5:0]           et,
                           input logic                 ee,
                           input logic [NUM_RO-1:0]    eroen,
                           input logic                 inj,
                           input logic [31:0]          inj_chal);
      exp_t e;
      exp_t g;
      int   n;
      bit   seen;
      e.resp = er;
      e.tie  = et;
      e.err  = ee;
      e.lat  = ee ? 1 : LAT;
      sb.push_back(e);
      @(negedge ACLK);
      start = 1'b1;
      challenge = chal;
      n = 0;
      seen = 0;
      while (!seen && n < 10000) begin
         @(negedge ACLK);
         n++;
         if (n == 1) begin
            start = 1'b0;
            chk("busy_after_start", busy, !ee);
         end
         if (n == 2 && !ee) chk("ro_en_pair0", ro_en, eroen);
         if (n == 100 && !ee) begin
            chk("mid_eval_resp", response, last_resp);
            if (inj) begin
               start = 1'b1;
               challenge = inj_chal;
            end
         end
         if (n == 101) start = 1'b0;
         if (done) seen = 1;
      end
      g = sb.pop_front();
      chk("latency", n, g.lat);
      chk("response", response, g.resp);
      chk("tie_cnt", tie_cnt, g.tie);
      chk("err", err, g.err);
      @(negedge ACLK);
      chk("done_pulse_end", done, 0);
      chk("busy_end", busy, 0);
      last_resp = g.resp;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      mode = 0;
      last_resp = '0;
      ARESETN = 1'b0;
      start = 1'b0;
      challenge = '0;
      repeat (4) @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (50) @(negedge ACLK);
      chk("rst_ro_en", ro_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_resp", response, 0);
      chk("rst_err", err, 0);
      chk("rst_tie", tie_cnt, 0);

      mode = 0;
      repeat (5) @(negedge ACLK);
      run_eval(32'h0000_0100, 4'hF, 6'd0, 1'b0, 16'h0003, 1'b0, 0);

      run_eval(32'h0000_1005, 4'hF, 6'd0, 1'b1, 16'h0000, 1'b0, 0);

      mode = 1;
      repeat (5) @(negedge ACLK);
      run_eval(32'h0000_0100, 4'h0, 6'd0, 1'b0, 16'h0003, 1'b0, 0);

      mode = 2;
      repeat (5) @(negedge ACLK);
      run_eval(32'h0000_010F, 4'h0, 6'd4, 1'b0, 16'h8001, 1'b0, 0);

      mode = 0;
      repeat (5) @(negedge ACLK);
      run_eval(32'h0000_0100, 4'hF, 6'd0, 1'b0, 16'h0003, 1'b1,
               32'h0000_0000);

      @(negedge ACLK);
      start = 1'b1;
      challenge = 32'h0000_0100;
      @(negedge ACLK);
      start = 1'b0;
      repeat (500) @(negedge ACLK);
      chk("busy_before_rst", busy, 1);
      ARESETN = 1'b0;
      #1;
      chk("abort_ro_en", ro_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_resp", response, 0);
      chk("abort_err", err, 0);
      chk("abort_tie", tie_cnt, 0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      last_resp = '0;
      repeat (3) @(negedge ACLK);
      run_eval(32'h0000_0100, 4'hF, 6'd0, 1'b0, 16'h0003, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ro_puf_eval_core.md
Name: ro_puf_eval_core

Overview:
- Ring-oscillator PUF evaluation engine.
- Sits directly downstream of the AXI4-Lite register slave in the PUF IP.
- The register slave writes a challenge and pulses start. This block enables the selected RO pair, counts edges over a fixed window, compares the two counts, and builds a RESP_BITS-wide response.
- The register slave reads response/status back.

Parameters:
NUM_RO, 16, number of ring oscillators; power of two, >= 4
CNT_W, 16, edge-counter width
WINDOW, 1024, ACLK cycles per count window, >= 2
SETTLE, 16, ACLK cycles between RO enable and count start, >= 1
RESP_BITS, 32, response bits per challenge, 1..32

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ignored while busy=1
challenge  in  32  [7:0]=base index, [15:8]=offset, [31:16] reserved/ignored
ro_in  in  NUM_RO  raw RO outputs, asynchronous to ACLK
ro_en  out  NUM_RO  RO enables; at most two bits set
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse at end of evaluation
response  out  RESP_BITS  last completed response
err  out  1  sticky; last challenge rejected
tie_cnt  out  6  number of equal-count comparisons in the last evaluation

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; counters 0.
- Input conditioning:
  - Each ro_in bit passes through a 2-FF synchronizer, then a rising-edge detector on ACLK.
  - Only the two selected channels are counted.
- Index math: IW=log2(NUM_RO). For pair k (0..RESP_BITS-1):
  - a = (base + k) mod NUM_RO
  - b = (base + k + offset) mod NUM_RO
  - Modulo is truncation to IW bits; bits above IW in base/offset are ignored.
- Challenge capture:
  - On start in IDLE: challenge is latched; err cleared; tie_cnt cleared; response held.
  - If offset[IW-1:0]==0: err<=1, done pulses next cycle, busy never asserts, response unchanged.
- FSM states:
  - IDLE: busy=0.
  - SETTLE: ro_en has bits a,b set; wait SETTLE cycles; counters cleared.
  - COUNT: WINDOW cycles; cnt_a/cnt_b increment on detected edges.
  - COMPARE: 1 cycle; shift register bit k <= (cnt_a > cnt_b); tie: bit=0, tie_cnt+1.
  - Next: if k<RESP_BITS-1 then k+1 -> SETTLE (ro_en switches to the new pair the same cycle), else DONE.
  - DONE: 1 cycle; response <= shift register; done=1; ro_en=0; -> IDLE.
- busy=1 in SETTLE/COUNT/COMPARE/DONE.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency, start to done: RESP_BITS*(SETTLE+WINDOW+1)+2 cycles.
- Response is updated atomically in DONE only; mid-evaluation reads return the previous response.
- start while busy: ignored, no side effects.
- start in the same cycle as DONE: ignored; accepted from IDLE on the next cycle.
- Reset mid-evaluation: immediate abort; ro_en=0; response=0; no done pulse.
- Edges within the last 2 synchronizer stages at window close are dropped (accepted measurement error).

Decomposition:
- Package ro_puf_pkg holds:
  - FSM state enum (IDLE, SETTLE, COUNT, COMPARE, DONE).
  - Challenge field offsets/widths.
  - The function computing pair indices.
- Sub-module ro_edge_counter: sync + edge detect + clear + saturating CNT_W counter. Instantiated twice, fed through a NUM_RO:1 mux for a and b.

Test Plan:
1. Reset, then idle 50 cycles -> all outputs 0, ro_en=0.
2. NUM_RO=16, WINDOW=1024, RESP_BITS=4, challenge=0x0000_0100 (base 0, offset 1); bench RO i toggles every 3+i ACLK -> every comparison has cnt_a>cnt_b; response=0xF; tie_cnt=0; done at cycle 4*(16+1024+1)+2=4166 after start.
3. Same, but with ro_in reversed (RO i toggles every 18-i) -> response=0x0; tie_cnt=0.
4. challenge=0x0000_1005 (offset 16 -> 0 mod 16) -> err=1; done 1 cycle after start; busy stays 0; response unchanged.
5. All ROs at identical period 4 -> response=0x0; tie_cnt=RESP_BITS. Also check wrap: base=15, offset=1 -> pair 0 enables ro_en=0x8001.
6. start pulsed mid-COUNT -> ignored. ARESETN dropped mid-COUNT -> outputs 0 immediately; a new start after release completes normally.
